// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared pipeline definitions: state encoding, register-index
//               width and NOP/bubble encodings for the pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int              REG_W    = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          IDEX_CTRL_W = 9;
    localparam logic [IDEX_CTRL_W-1:0] BUBBLE_CTRL = '0;

    function automatic logic load_use_hazard(
        input logic             memread,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter; i_clear restarts the count at i_inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            // A clear on an incrementing cycle counts that cycle as the first.
            r_count <= i_inc ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard control: load-use stalls, redirect flushes,
//               memory-wait freeze with timeout flag and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_memread,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                 c_WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TO_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_TO_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_mem_error;
    logic                w_wait;
    logic                w_load_use;
    logic [c_WAIT_W-1:0] w_wait_cnt;
    logic                w_pc_write;
    logic                w_ifid_write;
    logic                w_idex_write;
    logic                w_exmem_write;
    logic                w_ifid_flush;
    logic                w_idex_flush;

    assign w_wait     = mem_req && !mem_ready;
    assign w_load_use = load_use_hazard(idex_memread, idex_rt, ifid_rs,
                                        ifid_rt, ifid_uses_rt);

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_exmem_write = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
        end else if (w_wait) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
        end else if (ex_redirect) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_mem_error <= 1'b0;
        end else begin
            r_state <= w_wait ? MEM_WAIT : RUN;
            // Raised on the edge at which the wait counter reaches TIMEOUT.
            if (w_wait && (w_wait_cnt >= c_TO_LAST)) begin
                r_mem_error <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(c_WAIT_W), .MAX(c_TO_MAX)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear ((r_state == RUN) || !w_wait),
        .i_inc   (w_wait),
        .o_count (w_wait_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_inc   (!w_pc_write),
        .o_count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_inc   (!w_wait && ex_redirect),
        .o_count (flush_cnt)
    );

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign idex_write  = w_idex_write;
    assign exmem_write = w_exmem_write;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign mem_error   = r_mem_error;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed scoreboard bench for hazard_ctrl (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 32;
    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}
    localparam logic [5:0] c_NORM  = 6'b111100;
    localparam logic [5:0] c_RST   = 6'b000011;
    localparam logic [5:0] c_FRZ   = 6'b000000;
    localparam logic [5:0] c_REDIR = 6'b111111;
    localparam logic [5:0] c_LU    = 6'b001101;

    typedef struct {
        int         id;
        logic [5:0] ctl;
        int         stall;
        int         flush;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ifid_rs, ifid_rt, idex_rt;
    logic             ifid_uses_rt, idex_memread, ex_redirect, mem_req, mem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, mem_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_rt      (idex_rt),
        .idex_memread (idex_memread),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .exmem_write  (exmem_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .mem_error    (mem_error),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic vec(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] xrt, input logic mr,
                       input logic red, input logic mq, input logic mrdy,
                       input logic [5:0] ctl, input int st, input int fl,
                       input logic er);
        exp_t e;
        rst = r; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
        idex_rt = xrt; idex_memread = mr; ex_redirect = red;
        mem_req = mq; mem_ready = mrdy;
        e.id = n_vec; e.ctl = ctl; e.stall = st; e.flush = fl; e.err = er;
        sb.push_back(e);
        n_vec++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [5:0] act;
            e   = sb.pop_front();
            act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};
            n_cmp++;
            if (act !== e.ctl || stall_cnt !== CNT_W'(e.stall) ||
                flush_cnt !== CNT_W'(e.flush) || mem_error !== e.err) begin
                n_bad++;
                $display("FAIL vec%0d: ctl act=%b exp=%b stall act=%0d exp=%0d flush act=%0d exp=%0d err act=%b exp=%b",
                         e.id, act, e.ctl, stall_cnt, e.stall, flush_cnt, e.flush,
                         mem_error, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; idex_rt = '0;
        idex_memread = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        //  rst rs  rt  urt xrt mr red mq rdy  ctl      stall flush err
        vec(1, 0,  0,  0,  0,  0, 0,  0, 0,   c_RST,   0,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  0,  0, 0);
        vec(0, 8,  0,  0,  8,  1, 0,  0, 0,   c_LU,    0,  0, 0);
        vec(0, 8,  0,  0,  8,  0, 0,  0, 0,   c_NORM,  1,  0, 0);
        vec(0, 0,  0,  0,  0,  1, 0,  0, 0,   c_NORM,  1,  0, 0);
        vec(0, 3,  9,  0,  9,  1, 0,  0, 0,   c_NORM,  1,  0, 0);
        vec(0, 3,  9,  1,  9,  1, 0,  0, 0,   c_LU,    1,  0, 0);
        vec(0, 8,  0,  0,  8,  1, 1,  0, 0,   c_REDIR, 2,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  2,  1, 0);
        // three-cycle memory wait, then completion
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   2,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   3,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   4,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 1,   c_NORM,  5,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  5,  1, 0);
        // redirect held across a wait is applied afterwards
        vec(0, 0,  0,  0,  0,  0, 1,  1, 0,   c_FRZ,   5,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 1,  1, 1,   c_REDIR, 6,  1, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  6,  2, 0);
        // timeout: six wait cycles, error visible from the 5th
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   6,  2, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   7,  2, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   8,  2, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   9,  2, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,  10,  2, 1);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,  11,  2, 1);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 1,   c_NORM, 12,  2, 1);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM, 12,  2, 1);
        // reset on the second wait cycle
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,  12,  2, 1);
        vec(1, 0,  0,  0,  0,  0, 0,  1, 0,   c_RST,  13,  2, 1);
        vec(1, 0,  0,  0,  0,  0, 0,  0, 0,   c_RST,   0,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  0,  0, 0);
        // wait counter restarts from zero after reset
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   0,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   1,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   2,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   3,  0, 0);
        vec(0, 0,  0,  0,  0,  0, 0,  1, 0,   c_FRZ,   4,  0, 1);
        vec(0, 0,  0,  0,  0,  0, 0,  0, 0,   c_NORM,  5,  0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: pending act=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the write-enable and flush controls of the PC, IF/ID and ID/EX registers.
- Consumes the ID/EX destination and control fields, the EX redirect result, and the MEM-stage data-memory handshake.
- Resolves load-use stalls, branch/jump flushes and multi-cycle memory waits.
- Holds a wait-timeout FSM, a sticky error flag and saturating performance counters.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before mem_error is set (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, beq)
idex_rt  in  5  rt of instruction in ID/EX
idex_memread  in  1  ID/EX instruction is a load
ex_redirect  in  1  EX resolved taken branch or jump this cycle
mem_req  in  1  MEM stage has memread or memwrite active
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
idex_write  out  1  ID/EX load enable
exmem_write  out  1  EX/MEM and MEM/WB load enable
ifid_flush  out  1  load NOP into IF/ID
idex_flush  out  1  load bubble (all control bits 0) into ID/EX
mem_error  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Control outputs are combinational from state and inputs, so they act at the next rising edge. Counters and flags are registered.
- The FSM uses 2 states: RUN and MEM_WAIT. The next state is written on every rising edge.
- Reset (rst=1 sampled at the edge):
  - state goes to RUN; stall_cnt=0, flush_cnt=0, mem_error=0.
  - While rst is high, outputs are pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_flush=1.
  - Reset mid-wait abandons the wait immediately.
- Priority per cycle: memory wait > redirect > load-use > normal.
- Memory wait condition: mem_req=1 and mem_ready=0.
  - Freeze: all write enables = 0, both flushes = 0.
  - RUN moves to MEM_WAIT and the wait counter loads 1.
  - In MEM_WAIT the counter increments, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, mem_error is set the next edge and holds until rst. The freeze continues regardless.
  - mem_ready=1 or mem_req=0 returns the FSM to RUN in the same cycle: outputs evaluate as RUN and the counter clears.
- Redirect (ex_redirect=1, not waiting):
  - ifid_flush=1, idex_flush=1, all write enables = 1.
  - flush_cnt increments by 1, saturating at all-ones.
  - A redirect held during a memory wait is applied in the first non-wait cycle, because the EX stage stays frozen until then.
- Load-use condition: idex_memread=1 and idex_rt!=0 and (idex_rt==ifid_rs or (ifid_uses_rt=1 and idex_rt==ifid_rt)), with no redirect and no wait.
  - Outputs: pc_write=0, ifid_write=0, idex_write=1, idex_flush=1, ifid_flush=0, exmem_write=1.
  - This yields exactly one bubble. The next cycle ID/EX holds the bubble, so the condition clears.
- Load-use together with redirect: the redirect wins and no stall is inserted.
- Normal operation: all write enables = 1, flushes = 0.
- stall_cnt increments, saturating, on every non-reset cycle with pc_write=0. This includes both memory-wait and load-use cycles.
- Register 0 is never a hazard source.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants RUN=1'b0, MEM_WAIT=1'b1;
  - register-index width 5 and REG_ZERO constant;
  - the NOP/bubble encoding also used by the IF/ID and ID/EX registers.
- One sub-module, sat_counter (parameterised width, inc, clear, synchronous rst), instantiated for stall_cnt, flush_cnt and the wait counter.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt 0->1; next cycle (idex_memread=0) all enables=1.
- rt=0 and no-use filtering:
  - idex_rt=0 with ifid_rs=0 -> no stall.
  - idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 with the load-use condition true -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all enables 0 for 3 cycles and 1 on the 4th; stall_cnt=3; mem_error=0.
- Timeout: TIMEOUT=4, mem_req=1, mem_ready=0 held 6 cycles -> mem_error rises after the 4th wait cycle and stays 1 after mem_ready=1; rst clears it.
- Reset mid-wait: assert rst on the 2nd MEM_WAIT cycle -> state RUN, counters 0, both flushes 1 while rst is high; normal enables the first cycle after rst deasserts with no hazard inputs.
